insn_prefetcher: RTL and testbench



---
 rtl/insn_prefetcher.sv | 171 +++++++++++++++++
 tb/tb_insn_prefetcher.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/insn_prefetcher.sv
// Instruction prefetcher: sequential fetch PC, redirect/flush, and a DEPTH-entry
// prefetch FIFO in front of a 1-cycle-latency synchronous instruction memory.
// Optional performance counters are compiled in with `define INSN_PREFETCH_PERF_EN.
module insn_prefetcher #(
  parameter int unsigned              LEN_INSN      = 32,
  parameter int unsigned              MEM_INSN_ADDR = 10,
  parameter int unsigned              DEPTH         = 4,
  parameter logic [MEM_INSN_ADDR-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     mem_en_o,
  output logic [MEM_INSN_ADDR-1:0] mem_addr_o,
  input  logic [LEN_INSN-1:0]      mem_rdata_i,
  output logic                     insn_valid_o,
  input  logic                     insn_ready_i,
  output logic [LEN_INSN-1:0]      insn_o,
  output logic [MEM_INSN_ADDR-1:0] insn_pc_o,
  input  logic                     redirect_valid_i,
  input  logic [MEM_INSN_ADDR-1:0] redirect_pc_i
`ifdef INSN_PREFETCH_PERF_EN
  ,
  output logic [31:0]              perf_fetched_o,
  output logic [31:0]              perf_flushed_o
`endif
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned OccW = CntW + 1;

  logic [MEM_INSN_ADDR-1:0] fetch_pc_q, fetch_pc_d;
  logic [MEM_INSN_ADDR-1:0] pc_pipe_q, pc_pipe_d;
  logic                     inflight_q, inflight_d;
  logic                     kill_q, kill_d;
  logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]          count_q, count_d;

  logic [LEN_INSN-1:0]      data_q [DEPTH];
  logic [MEM_INSN_ADDR-1:0] pcs_q  [DEPTH];
  logic [LEN_INSN-1:0]      last_insn_q;
  logic [MEM_INSN_ADDR-1:0] last_pc_q;

  logic [OccW-1:0] occupancy;
  logic            issue;
  logic            empty;
  logic            push;
  logic            pop;

  // Issue/handshake decode; a pop in the same cycle does not free a slot for issue.
  always_comb begin
    occupancy    = OccW'(count_q) + OccW'(inflight_q);
    empty        = (count_q == '0);
    issue        = !redirect_valid_i && (occupancy < OccW'(DEPTH));
    mem_en_o     = !rst && issue;
    mem_addr_o   = fetch_pc_q;
    insn_valid_o = !empty && !redirect_valid_i;
    pop          = insn_valid_o && insn_ready_i;
    // A response landing in a redirect cycle belongs to the old stream.
    push         = inflight_q && !kill_q && !redirect_valid_i;
    // Head is read straight from registered storage; when empty show the last head seen.
    insn_o       = empty ? last_insn_q : data_q[rd_ptr_q];
    insn_pc_o    = empty ? last_pc_q   : pcs_q[rd_ptr_q];
  end

  // Next-state for fetch PC, response pipeline and FIFO pointers.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pc_pipe_d  = pc_pipe_q;
    inflight_d = issue;
    kill_d     = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (issue) begin
      fetch_pc_d = fetch_pc_q + 1'b1;
      pc_pipe_d  = fetch_pc_q;
    end
    if (redirect_valid_i) begin
      fetch_pc_d = redirect_pc_i;
      kill_d     = inflight_q;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      pc_pipe_q  <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pc_pipe_q  <= pc_pipe_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage and the hold-last-head registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pcs_q[i]  <= '0;
      end
      last_insn_q <= '0;
      last_pc_q   <= '0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q] <= mem_rdata_i;
        pcs_q[wr_ptr_q]  <= pc_pipe_q;
      end
      if (!empty) begin
        last_insn_q <= data_q[rd_ptr_q];
        last_pc_q   <= pcs_q[rd_ptr_q];
      end
    end
  end

`ifdef INSN_PREFETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flushed_q, perf_flushed_d;
  logic [32:0] fetched_sum;
  logic [32:0] flushed_sum;
  logic        resp_dropped;

  // Saturating counters: accepted pops, and entries/responses thrown away by redirects.
  always_comb begin
    resp_dropped   = inflight_q && (kill_q || redirect_valid_i);
    fetched_sum    = {1'b0, perf_fetched_q} + 33'(pop);
    flushed_sum    = {1'b0, perf_flushed_q} + 33'(resp_dropped)
                   + (redirect_valid_i ? 33'(count_q) : 33'd0);
    perf_fetched_d = fetched_sum[32] ? 32'hFFFF_FFFF : fetched_sum[31:0];
    perf_flushed_d = flushed_sum[32] ? 32'hFFFF_FFFF : flushed_sum[31:0];
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
    end
  end

  assign perf_fetched_o = perf_fetched_q;
  assign perf_flushed_o = perf_flushed_q;
`endif

endmodule

// File: tb/tb_insn_prefetcher.sv
// Scoreboard bench for insn_prefetcher: stimulus queues the expected PCs, a negedge
// monitor checks every accepted instruction (PC and data) against the queue.
module tb_insn_prefetcher;
  localparam int unsigned LW  = 32;
  localparam int unsigned AW  = 10;
  localparam int unsigned DEP = 4;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_rdata;
  logic          insn_valid;
  logic          insn_ready;
  logic [LW-1:0] insn;
  logic [AW-1:0] insn_pc;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
`ifdef INSN_PREFETCH_PERF_EN
  logic [31:0]   perf_fetched;
  logic [31:0]   perf_flushed;
`endif

  int tests = 0;
  int fails = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] mon_pc;

  insn_prefetcher #(
    .LEN_INSN     (LW),
    .MEM_INSN_ADDR(AW),
    .DEPTH        (DEP),
    .RESET_PC     (10'h010)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_en_o        (mem_en),
    .mem_addr_o      (mem_addr),
    .mem_rdata_i     (mem_rdata),
    .insn_valid_o    (insn_valid),
    .insn_ready_i    (insn_ready),
    .insn_o          (insn),
    .insn_pc_o       (insn_pc),
    .redirect_valid_i(redirect_valid),
    .redirect_pc_i   (redirect_pc)
`ifdef INSN_PREFETCH_PERF_EN
    ,
    .perf_fetched_o  (perf_fetched),
    .perf_flushed_o  (perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous memory, one cycle of read latency.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= {22'b0, mem_addr} ^ KEY;
  end

  function automatic logic [31:0] data_of(input logic [AW-1:0] pc);
    return {22'b0, pc} ^ KEY;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted head must be the next expected PC with matching data.
  always @(negedge clk) begin
    if (!rst && insn_valid && insn_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pop: got pc %h, required no delivery", insn_pc);
      end else begin
        mon_pc = exp_q.pop_front();
        check("pop_pc", 32'(insn_pc), 32'(mon_pc));
        check("pop_data", insn, data_of(mon_pc));
      end
    end
  end

  // Wait (bounded) until the monitor has consumed every expected PC; exits just after a posedge.
  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s: got %0d pcs undelivered, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic push_seq(input logic [AW-1:0] start, input int n);
    logic [AW-1:0] p = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(p);
      p = p + 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst            = 1'b1;
    insn_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Reset state and first-fetch latency.
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_valid", 32'(insn_valid), 32'd0);
    check("rst_insn", insn, 32'd0);
    check("rst_insn_pc", 32'(insn_pc), 32'd0);
    push_seq(10'h010, 8);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("c0_mem_en", 32'(mem_en), 32'd1);
    check("c0_mem_addr", 32'(mem_addr), 32'h010);
    check("c0_valid", 32'(insn_valid), 32'd0);
    @(negedge clk);
    check("c1_valid", 32'(insn_valid), 32'd0);
    @(negedge clk);
    check("c2_valid", 32'(insn_valid), 32'd1);
    check("c2_pc", 32'(insn_pc), 32'h010);
    wait_drain("stream_drain", 40);

    // Back-pressure: FIFO fills to DEPTH and issue stops.
    insn_ready = 1'b0;
    exp_q.push_back(10'h018);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("full_mem_en", 32'(mem_en), 32'd0);
    check("full_mem_addr", 32'(mem_addr), 32'h01C);
    check("full_valid", 32'(insn_valid), 32'd1);
    check("full_head_pc", 32'(insn_pc), 32'h018);

    // One pop leaves 3 entries; next cycle issues a read; then redirect.
    @(posedge clk); #1 insn_ready = 1'b1;
    @(posedge clk); #1 insn_ready = 1'b0;
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 10'h200;
    insn_ready     = 1'b1;
    push_seq(10'h200, 4);
    @(negedge clk);
    check("r_valid", 32'(insn_valid), 32'd0);
    check("r_mem_en", 32'(mem_en), 32'd0);
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    check("r1_mem_en", 32'(mem_en), 32'd1);
    check("r1_mem_addr", 32'(mem_addr), 32'h200);
    check("r1_valid", 32'(insn_valid), 32'd0);
    @(negedge clk);
    check("r2_valid", 32'(insn_valid), 32'd0);
    @(negedge clk);
    check("r3_valid", 32'(insn_valid), 32'd1);
    check("r3_pc", 32'(insn_pc), 32'h200);
    wait_drain("redirect_drain", 40);

    // Back-to-back redirects: only the second target is fetched.
    redirect_valid = 1'b1;
    redirect_pc    = 10'h100;
    push_seq(10'h300, 4);
    @(posedge clk); #1 redirect_pc = 10'h300;
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    check("b1_valid", 32'(insn_valid), 32'd0);
    @(negedge clk);
    check("b2_valid", 32'(insn_valid), 32'd0);
    @(negedge clk);
    check("b3_pc", 32'(insn_pc), 32'h300);
    wait_drain("b2b_drain", 40);

    // Address wrap at the top of the space.
    redirect_valid = 1'b1;
    redirect_pc    = 10'h3FE;
    push_seq(10'h3FE, 4);
    @(posedge clk); #1 redirect_valid = 1'b0;
    wait_drain("wrap_drain", 40);

    // Fill, then reset mid-stream.
    insn_ready = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("pre_rst_mem_en", 32'(mem_en), 32'd0);
    check("pre_rst_valid", 32'(insn_valid), 32'd1);
`ifdef INSN_PREFETCH_PERF_EN
    check("perf_fetched", perf_fetched, 32'd21);
    check("perf_flushed", perf_flushed, 32'd8);
`endif
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(insn_valid), 32'd0);
    check("mid_rst_mem_en", 32'(mem_en), 32'd0);
    check("mid_rst_insn", insn, 32'd0);
    check("mid_rst_pc", 32'(insn_pc), 32'd0);
`ifdef INSN_PREFETCH_PERF_EN
    check("perf_fetched_rst", perf_fetched, 32'd0);
`endif
    push_seq(10'h010, 4);
    insn_ready = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("restart_mem_en", 32'(mem_en), 32'd1);
    check("restart_addr", 32'(mem_addr), 32'h010);
    wait_drain("restart_drain", 40);
    insn_ready = 1'b0;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
